// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and flattened-port slice helpers for reg_file_mp
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NREAD      = 2;
  localparam int RF_NWRITE     = 2;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Low bit of lane idx in a flattened bus of w-bit lanes.
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy-bit scoreboard with set-over-clear priority and sticky sb_err
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NREAD      = RF_NREAD,
  parameter int NWRITE     = RF_NWRITE,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWRITE-1:0]             wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0]  waddr,
  input  logic                          sb_set,
  input  logic [ADDR_WIDTH-1:0]         sb_addr,
  input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
  output logic [(2**ADDR_WIDTH)-1:0]    busy,
  output logic [NREAD-1:0]              rd_busy,
  output logic                          sb_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic             r_sb_err;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_set;
  logic             w_set_ok;
  logic             w_err;

  assign w_set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NWRITE; i++) begin
      if (wen[i]) begin
        w_clr[waddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_set = '0;
    if (w_set_ok) begin
      w_set[sb_addr] = 1'b1;
    end
  end

  // A re-issue only counts as an error if the old producer is not retiring this cycle.
  assign w_err = w_set_ok && r_busy[sb_addr] && !w_clr[sb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy   <= (r_busy & ~w_clr) | w_set;
      r_sb_err <= r_sb_err | w_err;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd_busy
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_hit;

    assign w_ra = raddr[lane_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];

    always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < NWRITE; i++) begin
        if (wen[i] && (waddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == w_ra)) begin
          w_hit = 1'b1;
        end
      end
    end

    assign rd_busy[k] = r_busy[w_ra]
                        && !((BYPASS != 0) && w_hit)
                        && !((ZERO_REG != 0) && (w_ra == '0));
  end

  assign busy   = r_busy;
  assign sb_err = r_sb_err;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with byte strobes, optional bypass and scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NREAD      = RF_NREAD,
  parameter int NWRITE     = RF_NWRITE,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]            raddr,
  output logic [NREAD*DATA_WIDTH-1:0]            rdata,
  output logic [NREAD-1:0]                       rd_busy,
  input  logic [NWRITE-1:0]                      wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0]           waddr,
  input  logic [NWRITE*strb_width(DATA_WIDTH)-1:0] wstrb,
  input  logic [NWRITE*DATA_WIDTH-1:0]           wdata,
  input  logic                                   sb_set,
  input  logic [ADDR_WIDTH-1:0]                  sb_addr,
  output logic [(2**ADDR_WIDTH)-1:0]             busy,
  output logic                                   sb_err
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;

  // Later ports are applied last, so port NWRITE-1 wins overlapping strobed bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wen[i] && wstrb[lane_lo(i, STRB_WIDTH) + b]
              && !((ZERO_REG != 0) && (waddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == '0))) begin
            r_mem[waddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]][b*8 +: 8]
              <= wdata[lane_lo(i, DATA_WIDTH) + b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_val;

    assign w_ra = raddr[lane_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];

    always_comb begin
      w_val = r_mem[w_ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWRITE; i++) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wen[i] && wstrb[lane_lo(i, STRB_WIDTH) + b]
                && (waddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == w_ra)) begin
              w_val[b*8 +: 8] = wdata[lane_lo(i, DATA_WIDTH) + b*8 +: 8];
            end
          end
        end
      end
      if (rst || ((ZERO_REG != 0) && (w_ra == '0))) begin
        w_val = '0;
      end
    end

    assign rdata[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH] = w_val;
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREAD      (NREAD),
    .NWRITE     (NWRITE),
    .BYPASS     (BYPASS),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .raddr   (raddr),
    .busy    (busy),
    .rd_busy (rd_busy),
    .sb_err  (sb_err)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (bypass and non-bypass instances)
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  raddr;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [7:0]  wstrb;
  logic [63:0] wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [31:0] busy_a, busy_b;
  logic        sb_err_a, sb_err_b;

  int n_tests;
  int n_fail;

  reg_file_mp #(.BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rd_busy(rd_busy_a),
    .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy_a), .sb_err(sb_err_a)
  );

  reg_file_mp #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rd_busy(rd_busy_b),
    .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy_b), .sb_err(sb_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wen    = '0;
    waddr  = '0;
    wstrb  = '0;
    wdata  = '0;
    sb_set = 1'b0;
    sb_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
    wen[p]           = 1'b1;
    waddr[p*5 +: 5]  = a;
    wstrb[p*4 +: 4]  = s;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_wr(0, 5'd5, 4'hf, 32'h12345678);
    sb_set = 1'b1; sb_addr = 5'd2;
    @(posedge clk); #1;
    idle();
    raddr = {5'd2, 5'd5};
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h12345678) begin
      n_fail++; $display("FAIL reset_pre_r5: got %h expected %h", rdata_a[31:0], 32'h12345678);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata_a, rdata_b);
    end
    n_tests++;
    if (busy_a !== 32'h0 || busy_b !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy: got %h/%h expected 0", busy_a, busy_b);
    end
    n_tests++;
    if (sb_err_a !== 1'b0 || sb_err_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_sb_err: got %b/%b expected 0", sb_err_a, sb_err_b);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_r5_after: got %h/%h expected 0", rdata_a[31:0], rdata_b[31:0]);
    end
  endtask

  task automatic test_strobes();
    @(negedge clk);
    idle();
    raddr = {5'd0, 5'd3};
    set_wr(0, 5'd3, 4'hf, 32'h11223344);
    set_wr(1, 5'd3, 4'h3, 32'hAABBCCDD);
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h1122CCDD) begin
      n_fail++; $display("FAIL strb_bypass_merge: got %h expected %h", rdata_a[31:0], 32'h1122CCDD);
    end
    n_tests++;
    if (rdata_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL strb_nobypass_old: got %h expected %h", rdata_b[31:0], 32'h0);
    end
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h1122CCDD || rdata_b[31:0] !== 32'h1122CCDD) begin
      n_fail++; $display("FAIL strb_stored: got %h/%h expected %h", rdata_a[31:0], rdata_b[31:0], 32'h1122CCDD);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle();
    set_wr(0, 5'd10, 4'hf, 32'h01010101);
    set_wr(1, 5'd11, 4'hf, 32'h02020202);
    @(negedge clk);
    idle();
    set_wr(0, 5'd10, 4'h8, 32'hFF000000);
    @(negedge clk);
    idle();
    raddr = {5'd11, 5'd10};
    #1;
    n_tests++;
    if (rdata_a !== {32'h02020202, 32'hFF010101} || rdata_b !== {32'h02020202, 32'hFF010101}) begin
      n_fail++; $display("FAIL b2b_two_ports: got %h/%h expected %h", rdata_a, rdata_b, {32'h02020202, 32'hFF010101});
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    raddr = {5'd0, 5'd7};
    set_wr(0, 5'd7, 4'hf, 32'hDEADBEEF);
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata_a[31:0], 32'hDEADBEEF);
    end
    n_tests++;
    if (rdata_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h expected %h", rdata_b[31:0], 32'h0);
    end
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (rdata_b[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL nobypass_next_cycle: got %h expected %h", rdata_b[31:0], 32'hDEADBEEF);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle();
    raddr = {5'd0, 5'd0};
    set_wr(0, 5'd0, 4'hf, 32'hFFFFFFFF);
    sb_set = 1'b1; sb_addr = 5'd0;
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass: got %h expected 0", rdata_a[31:0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_stored: got %h/%h expected 0", rdata_a[31:0], rdata_b[31:0]);
    end
    n_tests++;
    if (busy_a[0] !== 1'b0 || sb_err_a !== 1'b0) begin
      n_fail++; $display("FAIL zero_sb: got busy0=%b err=%b expected 0/0", busy_a[0], sb_err_a);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    raddr = {5'd9, 5'd1};
    sb_set = 1'b1; sb_addr = 5'd9;
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (busy_a !== 32'h00000200 || busy_b !== 32'h00000200) begin
      n_fail++; $display("FAIL sb_set_busy: got %h/%h expected %h", busy_a, busy_b, 32'h00000200);
    end
    n_tests++;
    if (rd_busy_a !== 2'b10 || rd_busy_b !== 2'b10) begin
      n_fail++; $display("FAIL sb_rd_busy: got %b/%b expected 10", rd_busy_a, rd_busy_b);
    end
    @(negedge clk);
    set_wr(1, 5'd9, 4'h0, 32'h55555555);
    #1;
    n_tests++;
    if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b10) begin
      n_fail++; $display("FAIL sb_rd_busy_hit: got %b/%b expected 00/10", rd_busy_a, rd_busy_b);
    end
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (busy_a[9] !== 1'b0 || rdata_a[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL sb_clear_nostrb: got busy9=%b r9=%h expected 0/0", busy_a[9], rdata_a[63:32]);
    end
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd9;
    set_wr(0, 5'd9, 4'hf, 32'h0000CAFE);
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (busy_a[9] !== 1'b1 || sb_err_a !== 1'b0) begin
      n_fail++; $display("FAIL sb_set_wins: got busy9=%b err=%b expected 1/0", busy_a[9], sb_err_a);
    end
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd9;
    @(posedge clk); #1;
    idle();
    #1;
    n_tests++;
    if (sb_err_a !== 1'b1 || sb_err_b !== 1'b1) begin
      n_fail++; $display("FAIL sb_err_set: got %b/%b expected 1", sb_err_a, sb_err_b);
    end
    @(negedge clk);
    set_wr(0, 5'd9, 4'hf, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    n_tests++;
    if (sb_err_a !== 1'b1 || busy_a[9] !== 1'b0) begin
      n_fail++; $display("FAIL sb_err_sticky: got err=%b busy9=%b expected 1/0", sb_err_a, busy_a[9]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    set_wr(0, 5'd4, 4'hf, 32'h0BADF00D);
    @(negedge clk);
    idle();
    raddr = {5'd0, 5'd4};
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL arst_pre: got %h expected %h", rdata_a[31:0], 32'h0BADF00D);
    end
    @(negedge clk);
    set_wr(0, 5'd4, 4'hf, 32'h77777777);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0 || sb_err_a !== 1'b0) begin
      n_fail++; $display("FAIL arst_no_edge: got %h/%h err=%b expected 0", rdata_a[31:0], rdata_b[31:0], sb_err_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    n_tests++;
    if (rdata_a[31:0] !== 32'h0 || rdata_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL arst_after: got %h/%h expected 0", rdata_a[31:0], rdata_b[31:0]);
    end
    n_tests++;
    if (busy_a !== 32'h0) begin
      n_fail++; $display("FAIL arst_busy: got %h expected 0", busy_a);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    raddr   = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_strobes();
    test_back_to_back();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, the successor to the 2R1W 32x32 register file used by the CPU datapath.
- Configurable width, depth, read-port count and write-port count.
- Per-byte write strobes.
- Optional same-cycle write-to-read bypass.
- Busy-bit scoreboard that tracks pending writebacks for hazard detection.

Parameters:
DATA_WIDTH, 32, bits per register; must be a multiple of 8
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..2)
BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/scoreboard set

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high; clears all entries, busy bits and sb_err
raddr  in  NREAD*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NREAD*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NREAD  per read port: the addressed register has a pending writeback
wen  in  NWRITE  write enable per write port
waddr  in  NWRITE*ADDR_WIDTH  write addresses
wstrb  in  NWRITE*DATA_WIDTH/8  byte strobes per write port
wdata  in  NWRITE*DATA_WIDTH  write data
sb_set  in  1  mark register sb_addr busy (instruction issue)
sb_addr  in  ADDR_WIDTH  scoreboard set address
busy  out  2**ADDR_WIDTH  registered busy vector
sb_err  out  1  sticky flag: sb_set targeted an already-busy register

Behaviour:
Reset
- rst high at any time, independent of clk: all entries = 0, busy = 0, sb_err = 0.
- Writes and sb_set are ignored while rst is high.
- rdata is combinational, so every rdata reads 0 during reset.

Write (registered, rising clk edge)
- Byte b of entry waddr[i] <= wdata[i] byte b when wen[i] && wstrb[i][b].
- ZERO_REG=1 and waddr[i]==0: the write is dropped.
- Both ports hit the same address in the same cycle: bytes merge; where both strobes are set, port NWRITE-1 wins.
- wen with wstrb==0 writes nothing, but it still clears the busy bit.

Read (combinational, zero latency)
- ZERO_REG=1 and raddr==0: rdata = 0.
- BYPASS=1: each strobed byte of a same-cycle write to raddr is forwarded, using the same merge/priority rule as the write path. Unstrobed bytes come from the array.
- BYPASS=0: rdata returns the pre-edge stored value; the new value is visible from the next cycle.

Scoreboard (registered)
- busy[a] is cleared at the edge when any wen[i] && waddr[i]==a.
- busy[a] is set at the edge when sb_set && sb_addr==a.
- Set and clear of the same address in the same cycle: set wins, because the new producer supersedes.
- ZERO_REG=1: sb_set to address 0 is ignored and busy[0] stays 0.
- rd_busy[k] = busy[raddr_k] && !(BYPASS && a same-cycle wen hits raddr_k).
  - rd_busy[k] = 0 for address 0 when ZERO_REG=1.
- sb_err is set at the edge when sb_set hits an address that is busy and not cleared in that same cycle. It stays set until rst.

Widths
- All addresses are unsigned.
- Out-of-range values cannot occur, since depth is a full power of two.

Decomposition:
- Shared package/header `reg_file_pkg`: DATA_WIDTH and ADDR_WIDTH defaults, the STRB_WIDTH = DATA_WIDTH/8 derivation, and the slice helpers for flattened ports.
- One natural sub-module, `reg_scoreboard`: the busy vector, set/clear priority, sb_err and the rd_busy lookup.
- Storage, write merge and bypass muxes stay in the top module.

Test Plan:
1. Reset then read: rst=1 mid-run → all rdata=0, busy=0, sb_err=0. After release, a read of r5 returns 0.
2. Byte strobes and port priority: port0 writes r3=0x11223344 strb=1111 while port1 writes r3=0xAABBCCDD strb=0011 in the same cycle. Next cycle r3 reads 0x1122CCDD.
3. Bypass: BYPASS=1, write r7=0xDEADBEEF strb=1111 while raddr0=7 → rdata0=0xDEADBEEF in the same cycle. Repeat with BYPASS=0 → old value, then 0xDEADBEEF in the next cycle.
4. Zero register: write r0=0xFFFFFFFF plus sb_set r0 → rdata for r0 stays 0, busy[0]=0, sb_err=0.
5. Scoreboard:
   - sb_set r9 → busy[9]=1 and rd_busy=1 for raddr=9.
   - Writeback to r9 with wstrb=0 → busy[9]=0.
   - sb_set r9 together with a writeback to r9 → busy[9]=1, sb_err=0.
   - A further sb_set r9 → sb_err=1, held until rst.
6. Async reset mid-write: assert rst between edges while wen=1 to r4 → r4=0 with no clock edge. After release, r4 is still 0.
